instr_queue: RTL
================

# instr_queue

- Buffers 32-bit instructions from a host/testbench write port and issues them, in order, to one core over the `instr_if` valid/ready channel.
- Sits directly upstream of the core: it is the only driver of the core's `instr`/`valid` and honours the core's `ready`, which already folds in core-busy and instruction-done.
- Provides occupancy, flush and an issued-instruction counter for scoreboarding per core.

## Interface
Parameters:
- `DEPTH`, 8: queue entries; power of two, at least 2.
- `CORE_INDEX`, 0: owning core number; informational, no effect on behaviour.

Ports:
- `clk`  in  1: single clock; all state changes on the rising edge.
- `resetN`  in  1: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `flush`  in  1: discard all queued entries.
- `wr_valid`  in  1: host offers `wr_instr`.
- `wr_instr`  in  32: instruction word.
- `wr_ready`  out  1: queue accepts a write this cycle.
- `instr_out_if`  instr_if  -: source side of the channel. Drives `instr` (32) and `valid` (1); samples `ready` (1).
- `count`  out  $clog2(DEPTH)+1: current occupancy, 0..DEPTH.
- `empty`  out  1: `count == 0`.
- `full`  out  1: `count == DEPTH`.
- `issued_count`  out  16: instructions handed to the core since reset.

## Operation
- Circular buffer of `DEPTH` x 32 bits.
  - Read and write pointers are `$clog2(DEPTH)+1` bits wide; the extra MSB distinguishes full from empty.
  - Pointers wrap modulo `2*DEPTH`.
- Push: `wr_valid && wr_ready`. Writes `wr_instr` at the write pointer and increments the write pointer.
- Pop: `valid && ready`. Increments the read pointer and increments `issued_count`.
- Output signals:
  - `wr_ready = !full && !flush`.
  - `valid = !empty`.
  - `instr = mem[rd_ptr]`.
- Push and pop in the same cycle:
  - Both take effect.
  - `count` is unchanged.
- When full, a push is refused even if a pop occurs the same cycle. No simultaneous full-push.
- Flush:
  - Read pointer := write pointer, so `count` goes to 0 next cycle.
  - Flush beats any push or pop in the same cycle. No pop is counted that cycle.
  - Flush does not clear `issued_count`.
  - Flush is the only case where `valid` may drop without a handshake.
- `issued_count` wraps from 16'hFFFF to 0.
- Reset values:
  - Pointers 0, `count` 0, `empty` 1, `full` 0.
  - `wr_ready` 1 after reset; held 0 while `resetN` is low.
  - `valid` 0, `issued_count` 0.
  - `instr` is 32'h0, because memory is cleared to zero (NOP) on reset.
- Reset mid-operation discards all contents on that edge; no pop is counted.

## Timing
- Write-to-visible latency is 1 cycle. An entry pushed at edge N appears on `instr`/`valid` after edge N. There is no combinational fall-through.
- Pop takes effect at the same edge as the handshake. The next entry, if any, is presented in the following cycle with no bubble.
- The core's `ready` may drop for many cycles (ALU/memory busy, done pulse). While `ready` is low:
  - `instr` and `valid` hold stable.
  - `count` changes only by pushes.
- `ready` is used only in the handshake AND. There is no combinational path from `ready` to `valid`, to `instr`, or to `wr_ready`.
- `count`, `empty` and `full` are registered-pointer derived and reflect state after the last edge.

## Structure
- `INSTR_W = 32` and `ISSUE_CNT_W = 16` belong in `system_widths_pkg`.
- One optional sub-module, `instr_queue_mem`: DEPTH x 32 storage with one synchronous write port and one asynchronous read port.
- Pointer and flag logic stays in `instr_queue`.
- Expected size: roughly 150 lines of RTL.

## Test plan
1. Reset, then push 32'h1000_0001..32'h1000_0003 with `ready` held 1.
   - Each appears one cycle after its push, in order.
   - `issued_count` reaches 3; `empty` returns to 1.
2. `ready` = 0, push 8 words (DEPTH = 8).
   - `full` = 1, `wr_ready` = 0, `count` = 8.
   - A 9th push is not accepted.
   - `instr` holds the first word throughout.
3. Full queue, assert `ready` and `wr_valid` together for one cycle.
   - One pop occurs; the push is refused (`count` = 7).
   - The next cycle's push is accepted (`count` = 8).
4. Push 20 words with `ready` toggling every cycle to force pointer wrap.
   - Output order matches input order exactly.
   - `issued_count` = 20.
5. Queue at 5 entries, assert `flush` in the same cycle as a push and a pop.
   - `count` = 0 and `valid` = 0 next cycle.
   - `issued_count` unchanged.
6. Queue at 3 entries, drop `resetN` for 1 cycle.
   - All outputs return to their reset values at that edge.
   - Subsequent pushes start from entry 0.

Source files
------------

// File: rtl/system_widths_pkg.sv
// Shared datapath widths for the core-facing instruction path.
package system_widths_pkg;
   localparam int INSTR_W     = 32;
   localparam int ISSUE_CNT_W = 16;
endpackage

// File: rtl/instr_if.sv
// Valid/ready instruction channel between a queue (source) and a core (sink).
interface instr_if;
   logic [system_widths_pkg::INSTR_W-1:0] instr;
   logic                                  valid;
   logic                                  ready;

   modport source (output instr, output valid, input ready);
   modport sink   (input instr, input valid, output ready);
endinterface

// File: rtl/instr_queue_mem.sv
// DEPTH x INSTR_W storage: one synchronous write port, one asynchronous read port.
module instr_queue_mem
   import system_widths_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     resetN,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [INSTR_W-1:0]       wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [INSTR_W-1:0]       rdata
);

   logic [INSTR_W-1:0] mem_q [DEPTH];
   logic [INSTR_W-1:0] mem_d [DEPTH];

   always_comb begin
      mem_d = mem_q;
      if (we) begin
         mem_d[waddr] = wdata;
      end
   end

   // Cleared to zero so an idle queue presents a NOP.
   always_ff @(posedge clk) begin
      if (!resetN) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         mem_q <= mem_d;
      end
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/instr_queue.sv
// In-order instruction queue feeding one core over instr_if, with occupancy,
// flush and a wrapping issued-instruction counter.
module instr_queue
   import system_widths_pkg::*;
#(
   parameter int DEPTH      = 8,
   parameter int CORE_INDEX = 0
) (
   input  logic                     clk,
   input  logic                     resetN,
   input  logic                     flush,
   input  logic                     wr_valid,
   input  logic [INSTR_W-1:0]       wr_instr,
   output logic                     wr_ready,
   instr_if.source                  instr_out_if,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty,
   output logic                     full,
   output logic [ISSUE_CNT_W-1:0]   issued_count
);

   localparam int PTR_W = $clog2(DEPTH) + 1;
   localparam int AW    = PTR_W - 1;

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || CORE_INDEX < 0) begin : g_bad_param
      $error("instr_queue: DEPTH must be a power of two >= 2 and CORE_INDEX >= 0");
   end

   logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
   logic [ISSUE_CNT_W-1:0] issued_q, issued_d;
   logic                   push;
   logic                   pop;
   logic [INSTR_W-1:0]     rd_data;

   // Extra pointer MSB makes the difference DEPTH when full rather than 0.
   assign count    = wr_ptr_q - rd_ptr_q;
   assign empty    = (count == '0);
   assign full     = (count == PTR_W'(DEPTH));
   assign wr_ready = resetN && !full && !flush;

   assign instr_out_if.valid = !empty;
   assign instr_out_if.instr = rd_data;
   assign issued_count       = issued_q;

   assign push = wr_valid && wr_ready;
   assign pop  = instr_out_if.valid && instr_out_if.ready && !flush;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      issued_d = issued_q;
      if (flush) begin
         rd_ptr_d = wr_ptr_q;
      end else begin
         if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            issued_d = issued_q + ISSUE_CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!resetN) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         issued_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         issued_q <= issued_d;
      end
   end

   instr_queue_mem #(
      .DEPTH (DEPTH)
   ) u_mem (
      .clk    (clk),
      .resetN (resetN),
      .we     (push),
      .waddr  (wr_ptr_q[AW-1:0]),
      .wdata  (wr_instr),
      .raddr  (rd_ptr_q[AW-1:0]),
      .rdata  (rd_data)
   );

endmodule
